// File: rtl/obstacle_manager.sv
// obstacle_manager: NUM_OBS obstacle slots that spawn at the right edge,
// scroll left once per game tick while the game runs, and despawn off-screen.
// The scene freezes on a crash and is cleared when a new game starts.
// Optional feature macro: OBSTACLE_SPEEDUP_EN (speed +1 every 600 RUN ticks,
// saturating at 15). Without it the scroll speed is a constant BASE_SPEED.
module obstacle_manager #(
  parameter int NUM_OBS    = 2,
  parameter int POS_W      = 9,
  parameter int SPAWN_X    = 250,
  parameter int BASE_SPEED = 2,
  parameter int MIN_GAP    = 40,
  parameter int NUM_TYPES  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     game_tick,
  input  logic                     game_start,
  input  logic                     game_over,
  input  logic [7:0]               rng,
  output logic [NUM_OBS*POS_W-1:0] obs_pos,
  output logic [NUM_OBS*3-1:0]     obs_type,
  output logic [NUM_OBS-1:0]       obs_active,
  output logic                     spawn_pulse,
  output logic [3:0]               speed
);

  // Gap counter must hold MIN_GAP + 15 (largest reload value).
  localparam int                GAP_W     = $clog2(MIN_GAP + 16);
  localparam logic [POS_W-1:0]  SPAWN_POS = POS_W'(SPAWN_X);
  localparam logic [3:0]        BASE_SPD  = 4'(BASE_SPEED);
  localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(MIN_GAP);
  localparam logic [3:0]        TYPE_LIM  = 4'(NUM_TYPES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  state_e                   state_q;
  logic [NUM_OBS*POS_W-1:0] pos_q, pos_d;
  logic [NUM_OBS*3-1:0]     type_q, type_d;
  logic [NUM_OBS-1:0]       act_q, act_d;
  logic [NUM_OBS-1:0]       free_oh_s;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic                     spawn_q;
  logic                     spawn_en_s;
  logic [3:0]               speed_q, speed_d;
  logic [POS_W-1:0]         spd_ext_s;
  logic [POS_W-1:0]         slot_pos_s;
  logic [2:0]               new_type_s;
  logic                     unused_rng_s;

  // rng[3] takes no part in type or gap selection.
  assign unused_rng_s = rng[3];

  // Next slot/gap state for one RUN tick, computed from the pre-tick snapshot
  always_comb begin
    spd_ext_s  = POS_W'(speed_q);
    // Lowest inactive slot as a one-hot vector; zero when every slot is busy.
    free_oh_s  = ~act_q & (act_q + NUM_OBS'(1));
    spawn_en_s = (gap_q == '0) && (free_oh_s != '0);

    if ({1'b0, rng[2:0]} < TYPE_LIM) begin
      new_type_s = rng[2:0];
    end else begin
      new_type_s = 3'd0;
    end

    if (spawn_en_s) begin
      gap_d = GAP_INIT + GAP_W'(rng[7:4]);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end

    pos_d      = pos_q;
    type_d     = type_q;
    act_d      = act_q;
    slot_pos_s = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      slot_pos_s = pos_q[i*POS_W +: POS_W];
      if (spawn_en_s && free_oh_s[i]) begin
        // Freshly spawned slot is not moved on its spawn tick.
        pos_d[i*POS_W +: POS_W] = SPAWN_POS;
        type_d[i*3 +: 3]        = new_type_s;
        act_d[i]                = 1'b1;
      end else if (act_q[i] && (slot_pos_s >= spd_ext_s)) begin
        pos_d[i*POS_W +: POS_W] = slot_pos_s - spd_ext_s;
      end else if (act_q[i]) begin
        // Would scroll past the left edge: despawn.
        pos_d[i*POS_W +: POS_W] = '0;
        act_d[i]                = 1'b0;
      end else begin
        pos_d[i*POS_W +: POS_W] = slot_pos_s;
      end
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  logic [9:0] tick_cnt_q, tick_cnt_d;

  // Count RUN ticks and bump the speed every 600 ticks, saturating at 15
  always_comb begin
    if (tick_cnt_q == 10'd599) begin
      tick_cnt_d = 10'd0;
      if (speed_q == 4'd15) begin
        speed_d = speed_q;
      end else begin
        speed_d = speed_q + 4'd1;
      end
    end else begin
      tick_cnt_d = tick_cnt_q + 10'd1;
      speed_d    = speed_q;
    end
  end
`else
  // Scroll speed stays at its base value
  always_comb begin
    speed_d = speed_q;
  end
`endif

  // Game-state FSM and all registered slot/gap/speed state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      type_q     <= '0;
      act_q      <= '0;
      gap_q      <= GAP_INIT;
      spawn_q    <= 1'b0;
      speed_q    <= BASE_SPD;
`ifdef OBSTACLE_SPEEDUP_EN
      tick_cnt_q <= 10'd0;
`endif
    end else begin
      spawn_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FROZEN: begin
          // game_over wins over a simultaneous game_start: stay put.
          if (game_over) begin
            state_q <= state_q;
          end else if (game_start) begin
            state_q    <= ST_RUN;
            pos_q      <= '0;
            type_q     <= '0;
            act_q      <= '0;
            gap_q      <= GAP_INIT;
            speed_q    <= BASE_SPD;
`ifdef OBSTACLE_SPEEDUP_EN
            tick_cnt_q <= 10'd0;
`endif
          end else begin
            state_q <= state_q;
          end
        end
        ST_RUN: begin
          if (game_over) begin
            state_q <= ST_FROZEN;
          end else if (game_tick) begin
            pos_q      <= pos_d;
            type_q     <= type_d;
            act_q      <= act_d;
            gap_q      <= gap_d;
            spawn_q    <= spawn_en_s;
            speed_q    <= speed_d;
`ifdef OBSTACLE_SPEEDUP_EN
            tick_cnt_q <= tick_cnt_d;
`endif
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign obs_pos     = pos_q;
  assign obs_type    = type_q;
  assign obs_active  = act_q;
  assign spawn_pulse = spawn_q;
  assign speed       = speed_q;

endmodule
